// File: rtl/slot_dispatcher.sv
// slot_dispatcher
//   Samples the live slot index from the upstream counter, looks up a
//   per-slot command in a small writable table and issues it on a
//   valid/ready port. Back-pressure is returned upstream on `stall` so the
//   counter holds and no slot is skipped while the consumer is busy.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   count, count_en   slot index and advance strobe from the counter
//   stall             hold request to the counter (en = run & ~stall)
//   cfg_we/addr/act/data  table write port {act, cmd} at addr
//   out_valid/ready   output handshake
//   out_cmd, out_slot issued command and the slot it came from
//   round_done        one-cycle pulse after the last slot is sampled
//   err               sticky: an out-of-range slot index was sampled
//
// Optional build macro SLOT_DISPATCH_STALL_CNT_EN adds output
//   stall_cycles[15:0], a saturating count of cycles with stall high.
module slot_dispatcher #(
  parameter int NUM_SLOTS   = 15,
  parameter int COUNT_WIDTH = 4,
  parameter int CMD_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   count_en,
  output logic                   stall,
  input  logic                   cfg_we,
  input  logic [COUNT_WIDTH-1:0] cfg_addr,
  input  logic                   cfg_act,
  input  logic [CMD_WIDTH-1:0]   cfg_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CMD_WIDTH-1:0]   out_cmd,
  output logic [COUNT_WIDTH-1:0] out_slot,
  output logic                   round_done,
  output logic                   err
`ifdef SLOT_DISPATCH_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  // Table is sized to the full index space so any index reads safely;
  // entries at or above NUM_SLOTS are never written and stay inactive.
  localparam int DEPTH = 1 << COUNT_WIDTH;
  localparam logic [COUNT_WIDTH:0]   SLOTS_W   = (COUNT_WIDTH+1)'(NUM_SLOTS);
  localparam logic [COUNT_WIDTH-1:0] LAST_SLOT = COUNT_WIDTH'(NUM_SLOTS - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state;
  logic                   tbl_act [DEPTH];
  logic [CMD_WIDTH-1:0]   tbl_cmd [DEPTH];

  logic samp;
  logic in_range;
  logic cfg_ok;
  logic hit;

  // stall depends only on the state register and out_ready, never on
  // count_en, so the upstream enable gating has no combinational loop.
  assign stall     = (state == FULL) & ~out_ready;
  assign out_valid = (state == FULL);

  assign samp     = count_en & ~stall;
  assign in_range = {1'b0, count} < SLOTS_W;
  assign cfg_ok   = {1'b0, cfg_addr} < SLOTS_W;
  assign hit      = samp & in_range & tbl_act[count];

  // Output FSM: a hit always (re)loads the output register. A hit while
  // FULL implies out_ready=1 (otherwise stall blocks sampling), so this
  // gives back-to-back issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_cmd  <= '0;
      out_slot <= '0;
    end else begin
      if (hit) begin
        out_cmd  <= tbl_cmd[count];
        out_slot <= count;
      end
      case (state)
        EMPTY:   if (hit) state <= FULL;
        FULL:    if (!hit && out_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

  // Table: non-blocking update gives read-before-write on a same-cycle
  // write and sample of one slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_act[i] <= 1'b0;
        tbl_cmd[i] <= '0;
      end
    end else if (cfg_we && cfg_ok) begin
      tbl_act[cfg_addr] <= cfg_act;
      tbl_cmd[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      round_done <= samp & (count == LAST_SLOT);
      err        <= err | (samp & ~in_range);
    end
  end

`ifdef SLOT_DISPATCH_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles <= '0;
    else if (stall) stall_cycles <= sat_inc16(stall_cycles);
  end
`endif

endmodule

// File: tb/tb_slot_dispatcher.sv
// Testbench for slot_dispatcher: directed scenarios followed by a random
// phase, all checked against a transaction-level reference model.
module tb_slot_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  count;
  logic        count_en;
  logic        stall;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic        cfg_act;
  logic [7:0]  cfg_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_cmd;
  logic [3:0]  out_slot;
  logic        round_done;
  logic        err;
`ifdef SLOT_DISPATCH_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  slot_dispatcher #(.NUM_SLOTS(15), .COUNT_WIDTH(4), .CMD_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .count(count), .count_en(count_en), .stall(stall),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_act(cfg_act), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_slot(out_slot), .round_done(round_done), .err(err)
`ifdef SLOT_DISPATCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the table as plain arrays, the output slot as a
  // single pending transaction, the counter as an integer.
  logic        m_act [16];
  logic [7:0]  m_tab [16];
  logic        m_valid;
  logic [7:0]  m_cmd;
  logic [3:0]  m_slot;
  logic        m_rd;
  logic        m_err;
  int          m_sc;
  int          cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_act[i] = 1'b0;
      m_tab[i] = 8'h00;
    end
    m_valid = 0; m_cmd = 0; m_slot = 0; m_rd = 0; m_err = 0; m_sc = 0; cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, out_valid, m_valid);
    check({tag, ".cmd"}, out_cmd, m_cmd);
    check({tag, ".slot"}, out_slot, m_slot);
    check({tag, ".round_done"}, round_done, m_rd);
    check({tag, ".err"}, err, m_err);
`ifdef SLOT_DISPATCH_STALL_CNT_EN
    check({tag, ".stall_cycles"}, stall_cycles, m_sc);
`endif
  endtask

  // One clock cycle. Called at posedge+1; drives inputs, checks stall,
  // advances the model, then checks registered outputs after the edge.
  task automatic step(input logic en, input int c, input logic rdy,
                      input logic we, input int a, input logic act, input logic [7:0] d);
    logic e_stall, samp;
    count_en = en; count = 4'(c); out_ready = rdy;
    cfg_we = we; cfg_addr = 4'(a); cfg_act = act; cfg_data = d;
    #1;
    e_stall = m_valid && !rdy;
    check("stall", stall, e_stall);
    samp = en && !e_stall;
    m_rd = samp && (c == 14);
    if (samp && c >= 15) m_err = 1;
    if (samp && c < 15 && m_act[c]) begin
      m_valid = 1; m_cmd = m_tab[c]; m_slot = 4'(c);
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (e_stall && m_sc < 65535) m_sc++;
    if (we && a < 15) begin m_act[a] = act; m_tab[a] = d; end
    if (samp && c == cnt) cnt = (cnt == 14) ? 0 : cnt + 1;
    @(posedge clk); #1;
    check_outputs("cyc");
  endtask

  task automatic tick(input logic rdy);
    step(1'b1, cnt, rdy, 1'b0, 0, 1'b0, 8'h00);
  endtask

  task automatic write(input int a, input logic act, input logic [7:0] d);
    step(1'b0, cnt, 1'b1, 1'b1, a, act, d);
  endtask

  task automatic run_to(input int slot);
    for (int i = 0; i < 20 && cnt != slot; i++) tick(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs("rst");
  endtask

  initial begin
    rst = 1'b1; count = 0; count_en = 0; out_ready = 1; cfg_we = 0;
    cfg_addr = 0; cfg_act = 0; cfg_data = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Empty table sweep: nothing issued, one round_done pulse.
    for (int i = 0; i < 16; i++) tick(1'b1);

    // Slots 2 and 3 issue back-to-back with no stall.
    write(2, 1'b1, 8'hA5);
    write(3, 1'b1, 8'h3C);
    run_to(2);
    tick(1'b1);
    check("issue_slot2", {out_slot, out_cmd}, {4'd2, 8'hA5});
    tick(1'b1);
    check("issue_slot3", {out_slot, out_cmd}, {4'd3, 8'h3C});
    run_to(0);

    // Slot 5 held with out_ready low; counter frozen at 6.
    write(5, 1'b1, 8'h11);
    write(6, 1'b1, 8'h66);
    run_to(5);
    tick(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      check("held_cmd", out_cmd, 8'h11);
    end
    tick(1'b1);
    check("resume_slot6", {out_valid, out_slot, out_cmd}, {1'b1, 4'd6, 8'h66});
    run_to(0);

    // Out-of-range index sets sticky err; cfg_addr 15 ignored.
    step(1'b1, 15, 1'b1, 1'b0, 0, 1'b0, 8'h00);
    check("err_set", err, 1'b1);
    write(15, 1'b1, 8'hFF);
    step(1'b1, 15, 1'b1, 1'b0, 0, 1'b0, 8'h00);
    check("oor_no_issue", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1);
    check("err_sticky", err, 1'b1);

    // Read-before-write collision on slot 4.
    write(4, 1'b1, 8'h22);
    run_to(4);
    step(1'b1, 4, 1'b1, 1'b1, 4, 1'b1, 8'h77);
    check("collision_old", out_cmd, 8'h22);
    run_to(4);
    tick(1'b1);
    check("collision_new", out_cmd, 8'h77);

    // Reset while a command is pending.
    write(7, 1'b1, 8'h5A);
    run_to(7);
    tick(1'b0);
    check("pending_before_rst", out_valid, 1'b1);
    do_reset();
    for (int i = 0; i < 16; i++) tick(1'b1);

    // Four stalled cycles after a fresh reset.
    do_reset();
    write(1, 1'b1, 8'h01);
    run_to(1);
    tick(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0);
`ifdef SLOT_DISPATCH_STALL_CNT_EN
    check("stall_cycles_4", stall_cycles, 16'd4);
`endif
    tick(1'b1);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      logic en, rdy, we, act;
      int c, a;
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 3) == 0);
      a   = $urandom_range(0, 15);
      act = ($urandom_range(0, 2) != 0);
      c   = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 15)) : cnt;
      step(en, c, rdy, we, a, act, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
